// File: rtl/ysyx_22040125_lsu_if.sv
// Execute/writeback and data-memory bundles for the LSU.
// master drives the request side of each bundle.
interface ysyx_22040125_lsu_ex_if #(
  parameter int ADDR_W = 32
);
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_load;
  logic              ex_store;
  logic [ADDR_W-1:0] ex_addr;
  logic [63:0]       ex_wdata;
  logic [5:0]        ex_l_bhw;
  logic [2:0]        ex_s_bhwd;
  logic              wb_valid;
  logic [63:0]       wb_rdata;
  logic              wb_err;

  modport master (
    output ex_valid, ex_load, ex_store,
    output ex_addr, ex_wdata,
    output ex_l_bhw, ex_s_bhwd,
    input  ex_ready,
    input  wb_valid, wb_rdata, wb_err
  );

  modport slave (
    input  ex_valid, ex_load, ex_store,
    input  ex_addr, ex_wdata,
    input  ex_l_bhw, ex_s_bhwd,
    output ex_ready,
    output wb_valid, wb_rdata, wb_err
  );
endinterface

interface ysyx_22040125_lsu_mem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [7:0]        mem_wstrb;
  logic [63:0]       mem_wdata;
  logic              mem_rsp_valid;
  logic [63:0]       mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_addr,
    output mem_wen, mem_wstrb, mem_wdata,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_addr,
    input  mem_wen, mem_wstrb, mem_wdata,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit: one transaction at a time from execute
// to the 64-bit data memory, formatted result to writeback.
module ysyx_22040125_lsu #(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22040125_lsu_ex_if.slave      ex,
  ysyx_22040125_lsu_mem_if.master    mem
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic              ex_ready_q, ex_ready_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [7:0]        strb_q, strb_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [63:0]       wb_rdata_q, wb_rdata_d;
  logic              wb_err_q, wb_err_d;
  logic [5:0]        lty_q, lty_d;
  logic [2:0]        off_q, off_d;
  logic              is_ld_q, is_ld_d;

  logic [2:0]  off;
  logic [5:0]  lt;
  logic [2:0]  st;
  logic        ld;
  logic        sz_b, sz_h, sz_w, sz_d;
  logic        ty_ok, misal, bad, acc;
  logic [7:0]  strb;
  logic [63:0] wsft, wmsk;
  logic [63:0] rsft, fmt;

  assign off = ex.ex_addr[2:0];
  assign lt  = ex.ex_l_bhw;
  assign st  = ex.ex_s_bhwd;
  assign ld  = ex.ex_load;

  assign sz_b = ld ? (lt[5] | lt[4]) : st[2];
  assign sz_h = ld ? (lt[3] | lt[2]) : st[1];
  assign sz_w = ld ? (lt[1] | lt[0]) : st[0];
  assign sz_d = ld ? (lt == '0) : (st == '0);

  assign ty_ok = ld ? $onehot0(lt) : $onehot0(st);
  assign misal = (sz_h & off[0])
               | (sz_w & (|off[1:0]))
               | (sz_d & (|off));
  assign bad = (ex.ex_load & ex.ex_store)
             | ~ty_ok
             | (ex.ex_addr < BASE)
             | misal;
  assign acc = ex.ex_valid & ex_ready_q
             & (ex.ex_load | ex.ex_store);

  assign strb = sz_b ? (8'h01 << off) :
                sz_h ? (8'h03 << off) :
                sz_w ? (8'h0F << off) :
                       8'hFF;
  assign wsft = ex.ex_wdata << {off, 3'b000};

  // Lanes outside the strobe are forced to zero.
  always_comb begin
    wmsk = '0;
    for (int i = 0; i < 8; i++) begin
      wmsk[8*i +: 8] = strb[i] ? wsft[8*i +: 8] : 8'h00;
    end
  end

  assign rsft = mem.mem_rsp_rdata >> {off_q, 3'b000};

  always_comb begin
    fmt = rsft;
    unique case (1'b1)
      lty_q[5]: fmt = {{56{rsft[7]}}, rsft[7:0]};
      lty_q[4]: fmt = {56'b0, rsft[7:0]};
      lty_q[3]: fmt = {{48{rsft[15]}}, rsft[15:0]};
      lty_q[2]: fmt = {48'b0, rsft[15:0]};
      lty_q[1]: fmt = {{32{rsft[31]}}, rsft[31:0]};
      lty_q[0]: fmt = {32'b0, rsft[31:0]};
      default:  fmt = rsft;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ex_ready_d  = ex_ready_q;
    req_valid_d = req_valid_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    strb_d      = strb_q;
    wdata_d     = wdata_q;
    wb_valid_d  = 1'b0;
    wb_rdata_d  = wb_rdata_q;
    wb_err_d    = wb_err_q;
    lty_d       = lty_q;
    off_d       = off_q;
    is_ld_d     = is_ld_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          ex_ready_d = 1'b0;
          if (bad) begin
            state_d    = DONE;
            wb_valid_d = 1'b1;
            wb_err_d   = 1'b1;
            wb_rdata_d = '0;
          end else begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            addr_d      = {ex.ex_addr[ADDR_W-1:3], 3'b000};
            wen_d       = ex.ex_store;
            strb_d      = ex.ex_store ? strb : 8'h00;
            wdata_d     = ex.ex_store ? wmsk : '0;
            lty_d       = ex.ex_load ? lt : '0;
            off_d       = off;
            is_ld_d     = ex.ex_load;
          end
        end
      end
      REQ: begin
        if (mem.mem_req_ready) begin
          state_d     = WAIT;
          req_valid_d = 1'b0;
        end
      end
      WAIT: begin
        if (mem.mem_rsp_valid) begin
          state_d    = DONE;
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b0;
          wb_rdata_d = is_ld_q ? fmt : '0;
        end
      end
      DONE: begin
        state_d    = IDLE;
        ex_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ex_ready_q  <= 1'b1;
      req_valid_q <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      strb_q      <= '0;
      wdata_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_rdata_q  <= '0;
      wb_err_q    <= 1'b0;
      lty_q       <= '0;
      off_q       <= '0;
      is_ld_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ex_ready_q  <= ex_ready_d;
      req_valid_q <= req_valid_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      strb_q      <= strb_d;
      wdata_q     <= wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_rdata_q  <= wb_rdata_d;
      wb_err_q    <= wb_err_d;
      lty_q       <= lty_d;
      off_q       <= off_d;
      is_ld_q     <= is_ld_d;
    end
  end

  assign ex.ex_ready      = ex_ready_q;
  assign ex.wb_valid      = wb_valid_q;
  assign ex.wb_rdata      = wb_rdata_q;
  assign ex.wb_err        = wb_err_q;
  assign mem.mem_req_valid = req_valid_q;
  assign mem.mem_addr      = addr_q;
  assign mem.mem_wen       = wen_q;
  assign mem.mem_wstrb     = strb_q;
  assign mem.mem_wdata     = wdata_q;

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Directed bench for the LSU with a small strobed memory
// responder and a programmable request-ready delay.
module tb_ysyx_22040125_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22040125_lsu_ex_if  exi();
  ysyx_22040125_lsu_mem_if mi();

  ysyx_22040125_lsu dut (
    .clk (clk),
    .rst (rst),
    .ex  (exi),
    .mem (mi)
  );

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b010000;
  localparam logic [5:0] LH  = 6'b001000;
  localparam logic [5:0] LHU = 6'b000100;
  localparam logic [5:0] LW  = 6'b000010;
  localparam logic [5:0] LWU = 6'b000001;
  localparam logic [5:0] LD  = 6'b000000;
  localparam logic [2:0] SB  = 3'b100;
  localparam logic [2:0] SH  = 3'b010;
  localparam logic [2:0] SD  = 3'b000;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  logic [63:0] dmem [16];
  int          rdy_wait = 0;
  bit          hold_rsp = 0;
  bit          pend     = 0;
  int          req_cnt  = 0;
  int          rsp_cnt  = 0;
  logic [31:0] l_addr;
  logic        l_wen;
  logic [7:0]  l_strb;
  logic [63:0] l_wdata;

  initial begin
    mi.mem_req_ready = 1'b0;
    mi.mem_rsp_valid = 1'b0;
    mi.mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      mi.mem_rsp_valid = 1'b0;
      if (pend && !hold_rsp) begin
        pend = 0;
        rsp_cnt++;
        mi.mem_rsp_valid = 1'b1;
        if (l_wen) begin
          for (int b = 0; b < 8; b++)
            if (l_strb[b])
              dmem[l_addr[6:3]][8*b +: 8] = l_wdata[8*b +: 8];
          mi.mem_rsp_rdata = '0;
        end else begin
          mi.mem_rsp_rdata = dmem[l_addr[6:3]];
        end
      end
      mi.mem_req_ready = 1'b0;
      if (mi.mem_req_valid) begin
        req_cnt++;
        if (rdy_wait > 0) rdy_wait--;
        else begin
          mi.mem_req_ready = 1'b1;
          l_addr  = mi.mem_addr;
          l_wen   = mi.mem_wen;
          l_strb  = mi.mem_wstrb;
          l_wdata = mi.mem_wdata;
          pend    = 1;
        end
      end
    end
  end

  task automatic issue(input bit ld, input bit st,
                       input logic [31:0] a,
                       input logic [63:0] wd,
                       input logic [5:0] lt,
                       input logic [2:0] sty);
    @(negedge clk);
    exi.ex_valid  = 1'b1;
    exi.ex_load   = ld;
    exi.ex_store  = st;
    exi.ex_addr   = a;
    exi.ex_wdata  = wd;
    exi.ex_l_bhw  = lt;
    exi.ex_s_bhwd = sty;
    @(negedge clk);
    exi.ex_valid = 1'b0;
    exi.ex_load  = 1'b0;
    exi.ex_store = 1'b0;
  endtask

  task automatic wait_wb(output logic [63:0] rd,
                         output logic er,
                         output int lat);
    lat = 0;
    while (!exi.wb_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!exi.wb_valid) check("wb_timeout", {63'b0, exi.wb_valid}, 64'd1);
    rd = exi.wb_rdata;
    er = exi.wb_err;
    @(negedge clk);
    check("wb_pulse", {63'b0, exi.wb_valid}, 64'd0);
    check("wb_hold", exi.wb_rdata, rd);
  endtask

  task automatic load(input string tag, input logic [31:0] a,
                      input logic [5:0] lt,
                      input logic [63:0] exp);
    logic [63:0] rd;
    logic er;
    int lat;
    issue(1, 0, a, '0, lt, SD);
    wait_wb(rd, er, lat);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, {63'b0, er}, 64'd0);
  endtask

  task automatic bad(input string tag, input bit ld, input bit st,
                     input logic [31:0] a,
                     input logic [5:0] lt,
                     input logic [2:0] sty);
    logic [63:0] rd;
    logic er;
    int lat, r0;
    r0 = req_cnt;
    issue(ld, st, a, 64'hFFFF, lt, sty);
    wait_wb(rd, er, lat);
    check({tag, "_err"}, {63'b0, er}, 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'd0);
    check({tag, "_rdata"}, rd, 64'd0);
    check({tag, "_noreq"}, 64'(req_cnt - r0), 64'd0);
  endtask

  logic [63:0] rd;
  logic        er;
  int          lat, r0, wbc;
  logic [31:0] a0;

  initial begin
    rst = 1'b1;
    exi.ex_valid  = 1'b0;
    exi.ex_load   = 1'b0;
    exi.ex_store  = 1'b0;
    exi.ex_addr   = '0;
    exi.ex_wdata  = '0;
    exi.ex_l_bhw  = '0;
    exi.ex_s_bhwd = '0;
    for (int i = 0; i < 16; i++) dmem[i] = '0;
    dmem[0] = 64'h0000_8000_0000_0000;
    dmem[1] = 64'hDEAD_BEEF_8765_4321;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'b0, exi.ex_ready}, 64'd1);
    check("rst_req", {63'b0, mi.mem_req_valid}, 64'd0);
    check("rst_wbv", {63'b0, exi.wb_valid}, 64'd0);
    check("rst_wbd", exi.wb_rdata, 64'd0);
    check("rst_err", {63'b0, exi.wb_err}, 64'd0);
    check("rst_addr", 64'(mi.mem_addr), 64'd0);
    check("rst_strb", 64'(mi.mem_wstrb), 64'd0);
    rst = 1'b0;

    issue(1, 0, 32'h8000_0005, '0, LB, SD);
    wait_wb(rd, er, lat);
    check("lb_data", rd, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_err", {63'b0, er}, 64'd0);
    check("lb_lat", 64'(lat), 64'd2);
    check("lb_addr", 64'(l_addr), 64'h8000_0000);
    check("lb_wen", {63'b0, l_wen}, 64'd0);
    check("lb_strb", 64'(l_strb), 64'd0);

    issue(0, 1, 32'h8000_0006, 64'h1234, LD, SH);
    wait_wb(rd, er, lat);
    check("sh_addr", 64'(l_addr), 64'h8000_0000);
    check("sh_wen", {63'b0, l_wen}, 64'd1);
    check("sh_strb", 64'(l_strb), 64'hC0);
    check("sh_wdata", l_wdata, 64'h1234_0000_0000_0000);
    check("sh_rdata", rd, 64'd0);
    check("sh_err", {63'b0, er}, 64'd0);

    issue(0, 1, 32'h8000_0003, 64'hAB, LD, SB);
    wait_wb(rd, er, lat);
    check("sb_strb", 64'(l_strb), 64'h08);
    check("sb_wdata", l_wdata, 64'h0000_0000_AB00_0000);

    load("lw_neg", 32'h8000_000C, LW, 64'hFFFF_FFFF_DEAD_BEEF);
    load("lhu", 32'h8000_000A, LHU, 64'h0000_0000_0000_8765);
    load("lh", 32'h8000_000A, LH, 64'hFFFF_FFFF_FFFF_8765);
    load("lbu", 32'h8000_000F, LBU, 64'h0000_0000_0000_00DE);
    load("lb_pos", 32'h8000_0008, LB, 64'h0000_0000_0000_0021);
    load("ld_mod", 32'h8000_0000, LD, 64'h1234_8000_AB00_0000);

    bad("lw_mis", 1, 0, 32'h8000_0002, LW, SD);
    bad("ld_base", 1, 0, 32'h7FFF_FFF8, LD, SD);
    bad("both", 1, 1, 32'h8000_0000, LD, SD);
    bad("ltype", 1, 0, 32'h8000_0000, 6'b000011, SD);
    bad("stype", 0, 1, 32'h8000_0000, LD, 3'b110);
    bad("sh_mis", 0, 1, 32'h8000_0001, LD, SH);
    bad("sd_mis", 0, 1, 32'h8000_0004, LD, SD);

    r0 = req_cnt;
    @(negedge clk);
    exi.ex_valid = 1'b1;
    exi.ex_addr  = 32'h8000_0000;
    wbc = 0;
    repeat (3) begin
      @(negedge clk);
      if (exi.wb_valid) wbc++;
    end
    exi.ex_valid = 1'b0;
    check("nop_ready", {63'b0, exi.ex_ready}, 64'd1);
    check("nop_wb", 64'(wbc), 64'd0);
    check("nop_req", 64'(req_cnt - r0), 64'd0);

    rdy_wait = 5;
    issue(1, 0, 32'h8000_0004, '0, LWU, SD);
    a0 = mi.mem_addr;
    check("stall_a0", 64'(a0), 64'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_vld", {63'b0, mi.mem_req_valid}, 64'd1);
      check("stall_addr", 64'(mi.mem_addr), 64'(a0));
      check("stall_strb", 64'(mi.mem_wstrb), 64'd0);
    end
    wait_wb(rd, er, lat);
    check("lwu_data", rd, 64'h0000_0000_1234_8000);

    hold_rsp = 1;
    issue(1, 0, 32'h8000_0008, '0, LD, SD);
    @(negedge clk);
    check("w_reqv", {63'b0, mi.mem_req_valid}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rw_ready", {63'b0, exi.ex_ready}, 64'd1);
    check("rw_req", {63'b0, mi.mem_req_valid}, 64'd0);
    check("rw_wbv", {63'b0, exi.wb_valid}, 64'd0);
    r0 = rsp_cnt;
    hold_rsp = 0;
    wbc = 0;
    repeat (5) begin
      @(negedge clk);
      if (exi.wb_valid) wbc++;
    end
    check("late_rsp_seen", 64'(rsp_cnt - r0), 64'd1);
    check("late_rsp_wb", 64'(wbc), 64'd0);
    check("late_ready", {63'b0, exi.ex_ready}, 64'd1);

    load("ld_after", 32'h8000_0008, LD, 64'hDEAD_BEEF_8765_4321);

    issue(0, 1, 32'h8000_0010, 64'h0123_4567_89AB_CDEF, LD, SD);
    wait_wb(rd, er, lat);
    check("sd_strb", 64'(l_strb), 64'hFF);
    check("sd_addr", 64'(l_addr), 64'h8000_0010);
    load("ld_back", 32'h8000_0010, LD, 64'h0123_4567_89AB_CDEF);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
